// File: rtl/leaf_collect_pkg.sv
// leaf_collect_pkg: shared constants and types for the leaf upstream collector
package leaf_collect_pkg;
  localparam int NUM_CHILD = 5;
  localparam int IDX_W = 3;
  localparam int DATA_W = 16;
  typedef logic [IDX_W-1:0] child_idx_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    child_idx_t idx;
  } up_word_t;
  function automatic child_idx_t next_ptr(input child_idx_t i);
    return (i == child_idx_t'(NUM_CHILD - 1)) ? child_idx_t'(0) : child_idx_t'(i + 1'b1);
  endfunction
endpackage

// File: rtl/rr_arbiter5.sv
// rr_arbiter5: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter5
  import leaf_collect_pkg::*;
(
  input  logic [NUM_CHILD-1:0] req,
  input  child_idx_t           ptr,
  input  logic                 en,
  output logic [NUM_CHILD-1:0] gnt,
  output child_idx_t           gnt_idx,
  output logic                 any
);
  child_idx_t c;
  // Scan farthest-first so the candidate nearest ptr overwrites the rest
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = NUM_CHILD - 1; k >= 0; k--) begin
      c = child_idx_t'((int'(ptr) + k) % NUM_CHILD);
      if (en && req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        gnt_idx = c;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/leaf_upstream_collector.sv
// leaf_upstream_collector: round-robin merge of five child words into one registered upstream channel; LEAF_COLLECTOR_CNT_EN adds grant_cnt
module leaf_upstream_collector
  import leaf_collect_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHILD-1:0]               child_valid,
  input  logic [NUM_CHILD-1:0][DATA_W-1:0]   child_data,
  output logic [NUM_CHILD-1:0]               child_ready,
  output logic                               up_valid,
  output logic [DATA_W-1:0]                  up_data,
  output logic [IDX_W-1:0]                   up_idx,
  input  logic                               up_ready,
  output logic                               busy
`ifdef LEAF_COLLECTOR_CNT_EN
  ,
  output logic [NUM_CHILD-1:0][15:0]         grant_cnt
`endif
);
  up_word_t word_q, word_d;
  logic valid_q, valid_d;
  child_idx_t ptr_q, ptr_d;
  logic load;
  logic [NUM_CHILD-1:0] gnt;
  child_idx_t gnt_idx;
  logic any;
  assign load = !valid_q || up_ready;
  // Reset gates the arbiter so no child word is taken during a reset cycle
  rr_arbiter5 u_arb (
    .req     (child_valid),
    .ptr     (ptr_q),
    .en      (load && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );
  assign child_ready = gnt;
  assign up_valid = valid_q;
  assign busy = valid_q;
  assign up_data = word_q.data;
  assign up_idx = word_q.idx;
  always_comb begin
    word_d = word_q;
    valid_d = load ? any : valid_q;
    ptr_d = ptr_q;
    if (any) begin
      word_d.data = child_data[gnt_idx];
      word_d.idx = gnt_idx;
      ptr_d = next_ptr(gnt_idx);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      valid_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      word_q <= word_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef LEAF_COLLECTOR_CNT_EN
  logic [NUM_CHILD-1:0][15:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CHILD; i++)
      cnt_d[i] = cnt_q[i] + {15'd0, gnt[i] && cnt_q[i] != 16'hFFFF};
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_leaf_upstream_collector.sv
// tb_leaf_upstream_collector: directed stimulus with literal checks plus a per-cycle behavioural model compare
module tb_leaf_upstream_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] cv = '0;
  logic [4:0][15:0] cd = '0;
  logic ur = 1'b1;
  logic [4:0] cr;
  logic uv, bsy;
  logic [15:0] ud;
  logic [2:0] ui;
`ifdef LEAF_COLLECTOR_CNT_EN
  logic [4:0][15:0] gc;
`endif
  int checks = 0;
  int errors = 0;

  leaf_upstream_collector dut (
    .clk(clk), .rst(rst), .child_valid(cv), .child_data(cd), .child_ready(cr),
    .up_valid(uv), .up_data(ud), .up_idx(ui), .up_ready(ur), .busy(bsy)
`ifdef LEAF_COLLECTOR_CNT_EN
    , .grant_cnt(gc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one buffered word, a rotating start position, saturating grant tallies
  bit m_started = 0;
  bit m_valid = 0;
  int m_data = 0, m_idx = 0, m_ptr = 0;
  int m_cnt [5] = '{default: 0};

  function automatic int winner(input int start, input logic [4:0] v);
    for (int k = 0; k < 5; k++)
      if (v[(start + k) % 5]) return (start + k) % 5;
    return -1;
  endfunction

  function automatic logic [4:0] exp_ready();
    int w;
    w = winner(m_ptr, cv);
    if (rst || (m_valid && !ur) || w < 0) return 5'b0;
    return 5'(1 << w);
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_started = 1;
      m_valid = 0; m_data = 0; m_idx = 0; m_ptr = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (!m_valid || ur) begin
      w = winner(m_ptr, cv);
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_data = int'(cd[w]);
        m_idx = w;
        m_ptr = (w + 1) % 5;
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_up_valid", 32'(uv), 32'(m_valid));
      check("model_busy", 32'(bsy), 32'(m_valid));
      check("model_child_ready", 32'(cr), 32'(exp_ready()));
      if (m_valid) begin
        check("model_up_data", 32'(ud), 32'(m_data));
        check("model_up_idx", 32'(ui), 32'(m_idx));
      end
`ifdef LEAF_COLLECTOR_CNT_EN
      for (int i = 0; i < 5; i++) check("model_grant_cnt", 32'(gc[i]), 32'(m_cnt[i]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_up_valid", 32'(uv), 32'd0);
    check("reset_up_data", 32'(ud), 32'd0);
    check("reset_up_idx", 32'(ui), 32'd0);
    check("reset_busy", 32'(bsy), 32'd0);
    // single child 2 word
    cv = 5'b00100; cd[2] = 16'h1234; ur = 1'b1;
    #1 check("c2_ready", 32'(cr), 32'b00100);
    tick();
    cv = 5'b01001;
    check("c2_up_valid", 32'(uv), 32'd1);
    check("c2_up_data", 32'(ud), 32'h1234);
    check("c2_up_idx", 32'(ui), 32'd2);
    #1 check("ptr3_ready", 32'(cr), 32'b01000);
    tick();
    cv = '0;
    check("ptr3_idx", 32'(ui), 32'd3);
    tick();
    tick();
    // all five valid: full-rate rotation with wrap
    do_reset();
    cv = 5'b11111;
    for (int i = 0; i < 5; i++) cd[i] = 16'hA000 + 16'(i);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_up_valid", 32'(uv), 32'd1);
      check("rr_up_idx", 32'(ui), 32'(k % 5));
      check("rr_up_data", 32'(ud), 32'hA000 + 32'(k % 5));
    end
    // upstream stall holds the word and blocks children
    ur = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("stall_ready", 32'(cr), 32'd0);
      tick();
      check("stall_idx", 32'(ui), 32'd0);
      check("stall_data", 32'(ud), 32'hA000);
    end
    ur = 1'b1;
    #1 check("release_ready", 32'(cr), 32'b00010);
    tick();
    check("release_idx", 32'(ui), 32'd1);
    cv = '0;
    tick();
    tick();
    // wrap from ptr 4: child 4, then 0, then ptr is 1
    do_reset();
    cv = 5'b01000;
    tick();
    cv = 5'b10001;
    #1 check("wrap_ready4", 32'(cr), 32'b10000);
    tick();
    check("wrap_idx4", 32'(ui), 32'd4);
    #1 check("wrap_ready0", 32'(cr), 32'b00001);
    tick();
    check("wrap_idx0", 32'(ui), 32'd0);
    cv = 5'b00011;
    #1 check("wrap_ready1", 32'(cr), 32'b00010);
    tick();
    check("wrap_idx1", 32'(ui), 32'd1);
    cv = '0;
    tick();
    tick();
    // reset with a buffered word and a pending child
    cv = 5'b00100;
    ur = 1'b0;
    tick();
    check("pre_rst_valid", 32'(uv), 32'd1);
    rst = 1'b1;
    ur = 1'b1;
    #1 check("rst_ready", 32'(cr), 32'd0);
    tick();
    rst = 1'b0;
    cv = '0;
    check("post_rst_valid", 32'(uv), 32'd0);
    check("post_rst_busy", 32'(bsy), 32'd0);
    cv = 5'b10100;
    #1 check("post_rst_ptr0", 32'(cr), 32'b00100);
    tick();
    cv = '0;
    tick();
    tick();
`ifdef LEAF_COLLECTOR_CNT_EN
    do_reset();
    cv = 5'b00010;
    repeat (3) tick();
    cv = '0;
    check("cnt1_three", 32'(gc[1]), 32'd3);
    do_reset();
    check("cnt1_cleared", 32'(gc[1]), 32'd0);
    cv = 5'b00010;
    repeat (65535) tick();
    check("cnt1_full", 32'(gc[1]), 32'hFFFF);
    tick();
    tick();
    check("cnt1_saturated", 32'(gc[1]), 32'hFFFF);
    cv = '0;
    tick();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
